// File: rtl/alu_arb_pwr_ctrl_if.sv
// rtl/alu_arb_pwr_ctrl_if.sv - request/response and ALU-side bundle for the ALU front-end controller
interface alu_arb_pwr_ctrl_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic [3:0]  req0_op;
   logic        req1_valid;
   logic        req1_ready;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic [3:0]  req1_op;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        alu_pwr_en;
   logic        iso_en;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_opcode;
   logic        alu_start;
   logic        alu_busy;
   logic [15:0] alu_result;

   // Environment view: requesters plus the ALU itself.
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output alu_busy, alu_result,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
      input  alu_pwr_en, iso_en, alu_a, alu_b, alu_opcode, alu_start
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  alu_busy, alu_result,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
      output alu_pwr_en, iso_en, alu_a, alu_b, alu_opcode, alu_start
   );
endinterface

// File: rtl/alu_arb_pwr_ctrl.sv
// rtl/alu_arb_pwr_ctrl.sv - round-robin front end and power sequencer for the shared multi-cycle ALU
module alu_arb_pwr_ctrl #(
   parameter int IDLE_TIMEOUT = 16,
   parameter int PWR_SETTLE   = 4,
   parameter int WDOG_LIMIT   = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_arb_pwr_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_OFF, S_PWR_UP, S_READY, S_ISSUE, S_WAIT, S_RESP, S_ISO
   } state_t;

   localparam int         CNT_W          = 16;
   localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1010;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_grant_q, last_grant_d;
   logic               owner_q, owner_d;
   logic               grant0, grant1, accept, acc_sel;
   logic [15:0]        acc_a, acc_b;
   logic [3:0]         acc_op;
   logic               rsp_load;
   logic [15:0]        rsp_data_d;
   logic               rsp_err_d;
   logic               iso_d;

   // last_grant_q=1 means req1 was served last, so req0 wins the next tie.
   assign grant0  = bus.req0_valid & (~bus.req1_valid | last_grant_q);
   assign grant1  = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
   assign accept  = (state_q == S_READY) & (grant0 | grant1);
   assign acc_sel = grant1;
   assign acc_a   = acc_sel ? bus.req1_a  : bus.req0_a;
   assign acc_b   = acc_sel ? bus.req1_b  : bus.req0_b;
   assign acc_op  = acc_sel ? bus.req1_op : bus.req0_op;

   assign bus.req0_ready = (state_q == S_READY) & grant0;
   assign bus.req1_ready = (state_q == S_READY) & grant1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 1'b1;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rsp_load     = 1'b0;
      rsp_data_d   = 16'h0000;
      rsp_err_d    = 1'b0;
      case (state_q)
         S_OFF: begin
            cnt_d = '0;
            if (bus.req0_valid | bus.req1_valid) state_d = S_PWR_UP;
         end
         S_PWR_UP: begin
            if (cnt_q == CNT_W'(PWR_SETTLE - 1)) state_d = S_READY;
         end
         S_READY: begin
            if (accept) begin
               owner_d      = acc_sel;
               last_grant_d = acc_sel;
               if (acc_op >= OP_ILLEGAL_MIN) begin
                  state_d   = S_RESP;
                  rsp_load  = 1'b1;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end else if (cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
               state_d = S_ISO;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (!bus.alu_busy) begin
               state_d    = S_RESP;
               rsp_load   = 1'b1;
               rsp_data_d = bus.alu_result;
            end else if (cnt_q == CNT_W'(WDOG_LIMIT - 1)) begin
               state_d   = S_RESP;
               rsp_load  = 1'b1;
               rsp_err_d = 1'b1;
            end
         end
         S_RESP:  state_d = S_READY;
         S_ISO:   state_d = S_OFF;
         default: state_d = S_OFF;
      endcase
      // One counter serves settle, idle and watchdog; every state change restarts it.
      if (state_d != state_q) cnt_d = '0;
   end

   assign iso_d = ~((state_d == S_READY) | (state_d == S_ISSUE) |
                    (state_d == S_WAIT)  | (state_d == S_RESP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_OFF;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
      end
   end

   // Outputs are registered off the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alu_pwr_en <= 1'b0;
         bus.iso_en     <= 1'b1;
         bus.alu_start  <= 1'b0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp_data   <= 16'h0000;
         bus.rsp_err    <= 1'b0;
         bus.alu_a      <= 16'h0000;
         bus.alu_b      <= 16'h0000;
         bus.alu_opcode <= 4'h0;
      end else begin
         bus.alu_pwr_en <= (state_d != S_OFF);
         bus.iso_en     <= iso_d;
         bus.alu_start  <= (state_d == S_ISSUE);
         bus.rsp0_valid <= (state_d == S_RESP) & ~owner_d;
         bus.rsp1_valid <= (state_d == S_RESP) &  owner_d;
         if (rsp_load) begin
            bus.rsp_data <= rsp_data_d;
            bus.rsp_err  <= rsp_err_d;
         end
         if (accept) begin
            bus.alu_a      <= acc_a;
            bus.alu_b      <= acc_b;
            bus.alu_opcode <= acc_op;
         end
      end
   end
endmodule
